// File: rtl/io_ctrl.sv
// I/O sequencer: converts one-cycle IN/OUT strobes from the control unit into
// valid/ready handshakes on one of four ports, stalling the CPU until done or timed out.
module io_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_ent,
  input  logic            s_sal,
  input  logic [1:0]      port,
  input  logic [DW-1:0]   wdata,
  input  logic [3:0]      out_ready,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  input  logic            err_clr,
  output logic            stall,
  output logic [3:0]      out_valid,
  output logic [DW-1:0]   out_data,
  output logic [3:0]      in_ready,
  output logic            rd_we,
  output logic [DW-1:0]   rdata,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t          state_q;
  logic [1:0]      port_q;
  logic [15:0]     cnt_q;
  logic [15:0]     cnt_d;
  logic [DW-1:0]   out_data_q;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   in_word_d;
  logic            err_q;
  logic [3:0]      out_valid_q;
  logic [3:0]      in_ready_q;
  logic            rd_we_q;
  logic            timeout_d;

  function automatic logic [3:0] onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  // Saturating increment so a wait state can never wrap the counter.
  assign cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout_d = (cnt_q == TO_LAST);
  assign in_word_d = in_data[int'(port_q)*DW +: DW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      port_q      <= 2'd0;
      cnt_q       <= 16'd0;
      out_data_q  <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 4'b0000;
      in_ready_q  <= 4'b0000;
      rd_we_q     <= 1'b0;
    end else begin
      rd_we_q <= 1'b0;
      // A timeout below overrides a simultaneous clear.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_ent) begin
            state_q    <= IN_WAIT;
            port_q     <= port;
            cnt_q      <= 16'd0;
            in_ready_q <= onehot(port);
          end else if (s_sal) begin
            state_q     <= OUT_WAIT;
            port_q      <= port;
            cnt_q       <= 16'd0;
            out_data_q  <= wdata;
            out_valid_q <= onehot(port);
          end
        end
        OUT_WAIT: begin
          if (out_ready[port_q]) begin
            state_q     <= DONE;
            out_valid_q <= 4'b0000;
          end else if (timeout_d) begin
            state_q     <= DONE;
            out_valid_q <= 4'b0000;
            err_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        IN_WAIT: begin
          if (in_valid[port_q]) begin
            state_q    <= DONE;
            in_ready_q <= 4'b0000;
            rdata_q    <= in_word_d;
            rd_we_q    <= 1'b1;
          end else if (timeout_d) begin
            state_q    <= DONE;
            in_ready_q <= 4'b0000;
            rdata_q    <= '0;
            rd_we_q    <= 1'b1;
            err_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The request cycle itself must already freeze the PC.
  assign stall = ((state_q == IDLE) & (s_ent | s_sal)) |
                 (state_q == OUT_WAIT) | (state_q == IN_WAIT);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_ready  = in_ready_q;
  assign rd_we     = rd_we_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed testbench for io_ctrl: instance a uses TIMEOUT=8, instance b TIMEOUT=4.
module tb_io_ctrl;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_ent, s_sal, err_clr;
  logic [1:0]      port;
  logic [DW-1:0]   wdata;
  logic [3:0]      out_ready, in_valid;
  logic [4*DW-1:0] in_data;

  logic            a_stall, a_rd_we, a_err;
  logic [3:0]      a_out_valid, a_in_ready;
  logic [DW-1:0]   a_out_data, a_rdata;
  logic            b_stall, b_rd_we, b_err;
  logic [3:0]      b_out_valid, b_in_ready;
  logic [DW-1:0]   b_out_data, b_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  io_ctrl #(.DW(DW), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .s_ent(s_ent), .s_sal(s_sal), .port(port),
    .wdata(wdata), .out_ready(out_ready), .in_valid(in_valid), .in_data(in_data),
    .err_clr(err_clr), .stall(a_stall), .out_valid(a_out_valid),
    .out_data(a_out_data), .in_ready(a_in_ready), .rd_we(a_rd_we),
    .rdata(a_rdata), .err(a_err)
  );

  io_ctrl #(.DW(DW), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .s_ent(s_ent), .s_sal(s_sal), .port(port),
    .wdata(wdata), .out_ready(out_ready), .in_valid(in_valid), .in_data(in_data),
    .err_clr(err_clr), .stall(b_stall), .out_valid(b_out_valid),
    .out_data(b_out_data), .in_ready(b_in_ready), .rd_we(b_rd_we),
    .rdata(b_rdata), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_ent = 0; s_sal = 0; err_clr = 0; port = 0; wdata = 0;
    out_ready = 0; in_valid = 0; in_data = 0;
  endtask

  task automatic do_reset();
    reset = 1; clear_inputs();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    tick(); #1;
    total_cnt++; if ({a_stall, a_out_valid, a_in_ready, a_rd_we, a_err} !== 11'd0) $display("FAIL reset_ctrl_a got=%b exp=0", {a_stall, a_out_valid, a_in_ready, a_rd_we, a_err}); else pass_cnt++;
    total_cnt++; if ({a_rdata, a_out_data} !== 16'd0) $display("FAIL reset_data_a got=%h exp=0000", {a_rdata, a_out_data}); else pass_cnt++;
    total_cnt++; if ({b_stall, b_out_valid, b_in_ready, b_rd_we, b_err, b_rdata, b_out_data} !== 27'd0) $display("FAIL reset_b got=%h exp=0", {b_stall, b_out_valid, b_in_ready, b_rd_we, b_err, b_rdata, b_out_data}); else pass_cnt++;
    reset = 0;
  endtask

  task automatic test_out();
    s_sal = 1; port = 2; wdata = 8'hA5; out_ready = 4'b0100;
    #1;
    total_cnt++; if (a_stall !== 1'b1) $display("FAIL out_req_stall got=%b exp=1", a_stall); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (a_out_valid !== 4'b0100) $display("FAIL out_valid got=%b exp=0100", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_out_data !== 8'hA5) $display("FAIL out_data got=%h exp=a5", a_out_data); else pass_cnt++;
    total_cnt++; if (a_stall !== 1'b1) $display("FAIL out_wait_stall got=%b exp=1", a_stall); else pass_cnt++;
    tick(); s_sal = 0; out_ready = 0; #1;
    total_cnt++; if ({a_stall, a_out_valid, a_rd_we, a_err} !== 7'd0) $display("FAIL out_done got=%b exp=0000000", {a_stall, a_out_valid, a_rd_we, a_err}); else pass_cnt++;
    total_cnt++; if (a_out_data !== 8'hA5) $display("FAIL out_data_hold got=%h exp=a5", a_out_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_in();
    int st;
    int bad;
    st = 0; bad = 0;
    s_ent = 1; port = 1;
    #1;
    if (a_stall === 1'b1) st++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin in_valid = 4'b0010; in_data[15:8] = 8'h3C; end
      #1;
      if (a_stall === 1'b1) st++;
      if (a_in_ready !== 4'b0010) bad++;
    end
    total_cnt++; if (st != 5) $display("FAIL in_stall_cycles got=%0d exp=5", st); else pass_cnt++;
    total_cnt++; if (bad != 0) $display("FAIL in_ready_wait bad_cycles got=%0d exp=0", bad); else pass_cnt++;
    tick(); s_ent = 0; in_valid = 0; in_data = 0; #1;
    total_cnt++; if ({a_rd_we, a_stall, a_in_ready} !== 6'b100000) $display("FAIL in_done got=%b exp=100000", {a_rd_we, a_stall, a_in_ready}); else pass_cnt++;
    total_cnt++; if (a_rdata !== 8'h3C) $display("FAIL in_rdata got=%h exp=3c", a_rdata); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (a_rd_we !== 1'b0 || a_rdata !== 8'h3C) $display("FAIL in_after got=%b/%h exp=0/3c", a_rd_we, a_rdata); else pass_cnt++;
  endtask

  task automatic test_out_timeout();
    int n;
    do_reset();
    s_sal = 1; port = 0; wdata = 8'h5A; out_ready = 0;
    #1;
    n = 0;
    while (a_stall === 1'b1 && n < 20) begin n++; tick(); #1; end
    total_cnt++; if (n != 9) $display("FAIL out_to_stall_cycles got=%0d exp=9", n); else pass_cnt++;
    total_cnt++; if ({a_err, a_rd_we, a_out_valid} !== 6'b100000) $display("FAIL out_to_done got=%b exp=100000", {a_err, a_rd_we, a_out_valid}); else pass_cnt++;
    s_sal = 0;
    tick(); #1;
    total_cnt++; if (a_err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", a_err); else pass_cnt++;
    err_clr = 1;
    tick(); err_clr = 0; #1;
    total_cnt++; if (a_err !== 1'b0) $display("FAIL err_clr got=%b exp=0", a_err); else pass_cnt++;
  endtask

  task automatic test_in_timeout();
    int n;
    do_reset();
    // Handshake exactly on the last wait cycle still counts as success.
    s_ent = 1; port = 3;
    #1;
    tick(); tick(); tick();
    tick(); in_valid = 4'b1000; in_data[31:24] = 8'h77; #1;
    total_cnt++; if (b_in_ready !== 4'b1000 || b_out_valid !== 4'b0000) $display("FAIL in3_wait got=%b/%b exp=1000/0000", b_in_ready, b_out_valid); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({b_rd_we, b_err, b_stall} !== 3'b100 || b_rdata !== 8'h77) $display("FAIL in_edge_done got=%b/%h exp=100/77", {b_rd_we, b_err, b_stall}, b_rdata); else pass_cnt++;
    s_ent = 0; in_valid = 0; in_data = 0;
    tick();
    s_ent = 1; port = 3;
    #1;
    n = 0;
    while (b_stall === 1'b1 && n < 20) begin n++; tick(); #1; end
    total_cnt++; if (n != 5) $display("FAIL in_to_stall_cycles got=%0d exp=5", n); else pass_cnt++;
    total_cnt++; if ({b_rd_we, b_err} !== 2'b11 || b_rdata !== 8'h00) $display("FAIL in_to_done got=%b/%h exp=11/00", {b_rd_we, b_err}, b_rdata); else pass_cnt++;
    s_ent = 0;
    tick();
  endtask

  task automatic test_both();
    do_reset();
    s_ent = 1; s_sal = 1; port = 1; wdata = 8'hFF;
    in_valid = 4'b0010; in_data[15:8] = 8'h42;
    #1;
    total_cnt++; if (a_stall !== 1'b1) $display("FAIL both_req_stall got=%b exp=1", a_stall); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (a_out_valid !== 4'b0000 || a_in_ready !== 4'b0010) $display("FAIL both_wait got=%b/%b exp=0000/0010", a_out_valid, a_in_ready); else pass_cnt++;
    tick(); #1;
    total_cnt++; if ({a_rd_we, a_stall, a_out_valid} !== 6'b100000 || a_rdata !== 8'h42) $display("FAIL both_done got=%b/%h exp=100000/42", {a_rd_we, a_stall, a_out_valid}, a_rdata); else pass_cnt++;
    tick(); s_ent = 0; s_sal = 0; in_valid = 0; #1;
    total_cnt++; if ({a_stall, a_in_ready, a_out_valid, a_rd_we} !== 10'd0) $display("FAIL both_no_second got=%b exp=0", {a_stall, a_in_ready, a_out_valid, a_rd_we}); else pass_cnt++;
    total_cnt++; if (a_out_data !== 8'h00) $display("FAIL both_out_data got=%h exp=00", a_out_data); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    s_ent = 1; port = 1; in_valid = 0; in_data = 0;
    #1;
    tick(); #1;
    total_cnt++; if (a_in_ready !== 4'b0010) $display("FAIL mid_wait got=%b exp=0010", a_in_ready); else pass_cnt++;
    tick(); reset = 1; s_ent = 0;
    tick(); #1;
    total_cnt++; if ({a_stall, a_out_valid, a_in_ready, a_rd_we, a_err} !== 11'd0 || a_rdata !== 8'h00) $display("FAIL mid_reset got=%b/%h exp=0/00", {a_stall, a_out_valid, a_in_ready, a_rd_we, a_err}, a_rdata); else pass_cnt++;
    reset = 0; in_valid = 4'b0010; in_data[15:8] = 8'h99;
    tick(); #1;
    total_cnt++; if ({a_rd_we, a_in_ready} !== 5'd0 || a_rdata !== 8'h00) $display("FAIL mid_late_valid got=%b/%h exp=0/00", {a_rd_we, a_in_ready}, a_rdata); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (a_rd_we !== 1'b0 || a_stall !== 1'b0) $display("FAIL mid_no_we got=%b/%b exp=0/0", a_rd_we, a_stall); else pass_cnt++;
    in_valid = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_out();
    test_in();
    test_out_timeout();
    test_in_timeout();
    test_both();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/io_ctrl.md
# io_ctrl

I/O sequencer between the CPU control unit and up to four peripheral ports. It turns the one-cycle IN (`s_ent`) and OUT (`s_sal`) strobes from the control unit into valid/ready handshakes on the selected port. It holds the CPU (`stall`) until the transfer completes or times out. It sits beside the control unit and drives the register-file write strobe for IN results.

## Interface
- `DW`, 8: data width of ports and register file.
- `TIMEOUT`, 255: max wait cycles per transfer, 1..65535; 16-bit counter.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_ent`  in  1  IN request from control unit (decoded opcode).
- `s_sal`  in  1  OUT request from control unit.
- `port`  in  2  port select, `opcode[1:0]`.
- `wdata`  in  DW  data to output (ALU/register/immediate path).
- `out_ready`  in  4  per-port peripheral accepts output.
- `in_valid`  in  4  per-port peripheral has input data.
- `in_data`  in  4*DW  per-port input data; port p at `[p*DW +: DW]`.
- `err_clr`  in  1  clears sticky `err`.
- `stall`  out  1  CPU must hold PC and opcode.
- `out_valid`  out  4  one-hot output valid.
- `out_data`  out  DW  latched output data.
- `in_ready`  out  4  one-hot input ready.
- `rd_we`  out  1  register-file write strobe for IN result.
- `rdata`  out  DW  IN result.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, OUT_WAIT, IN_WAIT, DONE.
- IDLE:
  - `s_ent` -> latch `port`, clear counter, go IN_WAIT.
  - else `s_sal` -> latch `port` and `wdata`, clear counter, go OUT_WAIT.
  - Both high: IN wins, OUT ignored.
- OUT_WAIT:
  - `out_valid[p]`=1 and `out_data`=latched data; other bits 0.
  - `out_ready[p]` -> DONE.
  - Else counter increments. Counter == TIMEOUT-1 -> set `err`, go DONE.
- IN_WAIT:
  - `in_ready[p]`=1.
  - `in_valid[p]` -> capture `in_data[p]` into `rdata`, go DONE.
  - Counter == TIMEOUT-1 without handshake -> `rdata`=0, set `err`, go DONE.
- DONE:
  - `stall`=0, so the CPU advances the PC this cycle.
  - `rd_we`=1 only if the completed transfer was IN (including timed-out IN).
  - `s_ent`/`s_sal` are ignored; the old opcode is still present.
  - Next state: IDLE.
- Ready/valid on other ports ignored; only the latched port is observed.
- A handshake on the same cycle as timeout counts as success: no `err`, real data.
- `err`:
  - Set on timeout, held until `err_clr` or `reset`.
  - `err_clr` and a new timeout on the same cycle -> `err` stays 1.
- Counter saturates; it never wraps inside a wait state.

## Timing
- `stall` = (IDLE & (`s_ent`|`s_sal`)) | OUT_WAIT | IN_WAIT.
  - It is combinational so the request cycle already freezes the PC.
- `out_valid`, `in_ready`, `rd_we`, `out_data`, `rdata` are registered/state-decoded, with no combinational path from peripheral inputs.
- Minimum instruction length is 3 cycles: request (IDLE) -> WAIT with handshake -> DONE.
- Each extra cycle without handshake adds one stall cycle.
- Timeout path: request + TIMEOUT wait cycles + DONE.
- `rdata` holds its value until the next IN completes.
- `out_data` holds until the next OUT latch.
- Reset (any state, mid-transfer included) on the next edge:
  - state IDLE, counter 0.
  - `stall`=0 (unless a request is present), `out_valid`=0, `in_ready`=0.
  - `rd_we`=0, `rdata`=0, `out_data`=0, `err`=0.
  - An in-flight handshake is abandoned and no `rd_we` is issued.

## Test plan
- OUT to port 2, `wdata`=0xA5, `out_ready[2]` held 1 -> `out_valid`=4'b0100 for 1 cycle, `out_data`=0xA5, `stall` high 2 cycles, DONE next, `err`=0.
- IN from port 1, `in_valid[1]` asserted 4 cycles after request with `in_data[1]`=0x3C -> `stall` high 5 cycles, then `rd_we`=1 and `rdata`=0x3C for one cycle; `in_ready`=4'b0010 throughout the wait.
- OUT to port 0, `out_ready` never asserted, TIMEOUT=8 -> `stall` high 9 cycles, `err`=1 in DONE. `err_clr` pulse -> `err`=0.
- IN timeout on port 3 with TIMEOUT=4 -> `rd_we`=1 with `rdata`=0x00, `err`=1.
  - Repeat with `in_valid[3]` rising exactly on the timeout cycle -> real data, `err`=0.
- `s_ent` and `s_sal` together on port 1 -> IN performed, `out_valid` stays 0.
  - Request held through DONE -> no second transfer.
- `reset` pulsed during IN_WAIT -> next cycle all outputs 0, state IDLE, a late `in_valid` is ignored, no `rd_we`.
